// File: rtl/ttl7420_dual_nand4_pkg.sv
// Shared helper for the 7420 replacement: the single 4-input NAND equation.
// Written with 4-state operators so a 0 on any input dominates X/Z.
package ttl7420_dual_nand4_pkg;

    function automatic logic nand4_f(
        input logic a,
        input logic b,
        input logic c,
        input logic d
    );
        return ~(a & b & c & d);
    endfunction

endpackage

// File: rtl/ttl7420_dual_nand4_nand4.sv
// One 4-input NAND gate; purely combinational, no clock or reset dependency.
module ttl7420_dual_nand4_nand4
    import ttl7420_dual_nand4_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    assign y = nand4_f(a, b, c, d);

endmodule

// File: rtl/ttl7420_dual_nand4.sv
// Dual 4-input NAND (7420 equivalent) with combinational outputs and
// synchronously reset registered copies for clocked consumers.
module ttl7420_dual_nand4
    import ttl7420_dual_nand4_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic p1a,
    input  logic p1b,
    input  logic p1c,
    input  logic p1d,
    output logic p1y,
    input  logic p2a,
    input  logic p2b,
    input  logic p2c,
    input  logic p2d,
    output logic p2y,
    output logic p1y_q,
    output logic p2y_q
);

    logic p1y_s;
    logic p2y_s;
    logic p1y_q_r;
    logic p2y_q_r;

    ttl7420_dual_nand4_nand4 u_gate1 (
        .a (p1a),
        .b (p1b),
        .c (p1c),
        .d (p1d),
        .y (p1y_s)
    );

    ttl7420_dual_nand4_nand4 u_gate2 (
        .a (p2a),
        .b (p2b),
        .c (p2c),
        .d (p2d),
        .y (p2y_s)
    );

    // Registered copies; reset loads the NAND-of-zeros value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p1y_q_r <= 1'b1;
            p2y_q_r <= 1'b1;
        end else begin
            p1y_q_r <= p1y_s;
            p2y_q_r <= p2y_s;
        end
    end

    assign p1y   = p1y_s;
    assign p2y   = p2y_s;
    assign p1y_q = p1y_q_r;
    assign p2y_q = p2y_q_r;

endmodule

// File: tb/tb_ttl7420_dual_nand4.sv
// Self-checking bench for ttl7420_dual_nand4: vector table plus scoreboard
// queue for the combinational outputs, hand sequences for the registered path.
module tb_ttl7420_dual_nand4;

    typedef struct {
        logic [3:0] g1;
        logic [3:0] g2;
        logic       e1;
        logic       e2;
    } vec_t;

    typedef struct {
        logic e1;
        logic e2;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_idle = 1'b0;
    logic       dut_clk;
    logic       resetn = 1'b0;
    logic [3:0] g1 = 4'h0;
    logic [3:0] g2 = 4'h0;
    logic       p1y, p2y, p1y_q, p2y_q;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;
    assign dut_clk = clk_idle ? 1'b0 : clk;

    ttl7420_dual_nand4 dut (
        .clk    (dut_clk),
        .resetn (resetn),
        .p1a    (g1[3]),
        .p1b    (g1[2]),
        .p1c    (g1[1]),
        .p1d    (g1[0]),
        .p1y    (p1y),
        .p2a    (g2[3]),
        .p2b    (g2[2]),
        .p2c    (g2[1]),
        .p2d    (g2[0]),
        .p2y    (p2y),
        .p1y_q  (p1y_q),
        .p2y_q  (p2y_q)
    );

    function automatic logic nand_model(input logic [3:0] v);
        return (v == 4'hF) ? 1'b0 : 1'b1;
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Drive one vector, queue its expectation, then pop and compare after settle.
    task automatic apply(input string name, input logic [3:0] v1, input logic [3:0] v2,
                         input logic e1, input logic e2);
        exp_t e;
        g1 = v1;
        g2 = v2;
        e.e1 = e1;
        e.e2 = e2;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            check1({name, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check1({name, "_p1y"}, p1y, e.e1);
            check1({name, "_p2y"}, p2y, e.e2);
        end
    endtask

    initial begin
        logic [3:0] n1, n2;
        logic [7:0] r;

        // Vector table: counting sweep, corners, independence.
        for (int n = 0; n < 20; n++) begin
            vec_t v;
            n1 = n[3:0];
            n2 = 4'(n + 1);
            v.g1 = n1;
            v.g2 = n2;
            v.e1 = (n == 15) ? 1'b0 : 1'b1;
            v.e2 = (n == 14) ? 1'b0 : 1'b1;
            tbl.push_back(v);
        end
        tbl.push_back('{g1: 4'h0, g2: 4'h0, e1: 1'b1, e2: 1'b1});
        tbl.push_back('{g1: 4'hF, g2: 4'hF, e1: 1'b0, e2: 1'b0});
        tbl.push_back('{g1: 4'hF, g2: 4'h7, e1: 1'b0, e2: 1'b1});
        tbl.push_back('{g1: 4'h7, g2: 4'hF, e1: 1'b1, e2: 1'b0});

        // Reset state of registered copies.
        resetn = 1'b0;
        @(posedge clk); #1;
        check1("reset_p1y_q", p1y_q, 1'b1);
        check1("reset_p2y_q", p2y_q, 1'b1);

        resetn = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply($sformatf("tbl%0d", i), tbl[i].g1, tbl[i].g2, tbl[i].e1, tbl[i].e2);
        end

        // Random vectors on both edges with the DUT clock idle and reset held.
        clk_idle = 1'b1;
        resetn   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(clk);
            r = 8'($urandom_range(0, 255));
            apply($sformatf("rnd%0d", i), r[7:4], r[3:0],
                  nand_model(r[7:4]), nand_model(r[3:0]));
        end
        clk_idle = 1'b0;

        // Registered path: reset held with all inputs high.
        @(negedge clk);
        g1 = 4'hF;
        g2 = 4'hF;
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check1($sformatf("rst_hold%0d_p1y_q", i), p1y_q, 1'b1);
            check1($sformatf("rst_hold%0d_p2y_q", i), p2y_q, 1'b1);
            check1($sformatf("rst_hold%0d_p1y", i), p1y, 1'b0);
            check1($sformatf("rst_hold%0d_p2y", i), p2y, 1'b0);
        end
        @(negedge clk);
        resetn = 1'b1;
        check1("pre_edge_p1y_q", p1y_q, 1'b1);
        @(posedge clk); #1;
        check1("release_p1y_q", p1y_q, 1'b0);
        check1("release_p2y_q", p2y_q, 1'b0);

        // One-cycle latency with independent gates.
        @(negedge clk);
        g1 = 4'hF;
        g2 = 4'h7;
        #1;
        check1("latency_hold_p2y_q", p2y_q, 1'b0);
        @(posedge clk); #1;
        check1("indep_p1y_q", p1y_q, 1'b0);
        check1("indep_p2y_q", p2y_q, 1'b1);

        // Mid-operation reset forces both copies high at the next edge.
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check1("midrst_p1y_q", p1y_q, 1'b1);
        check1("midrst_p2y_q", p2y_q, 1'b1);
        check1("midrst_p1y", p1y, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        g1 = 4'h7;
        g2 = 4'hF;
        @(posedge clk); #1;
        check1("swap_p1y_q", p1y_q, 1'b1);
        check1("swap_p2y_q", p2y_q, 1'b0);

        if (sb.size() != 0) begin
            check1("sb_drained", 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
